alu_issue_ctrl: RTL and testbench

Sequential issuer that drives the datapath ALU from the initiator side: accepts an operation request over a valid/ready handshake, decodes it into the 4-bit ALU control code, holds the operands stable across the ALU's registered evaluation, captures `ALUOut`/`zero`, and returns the result with a branch decision over a second valid/ready handshake. It sits between the multi-cycle control unit and the ALU, replacing direct combinational drive of `ALUControl`, `input1` and `input2`.

---
 rtl/alu_pkg.sv | 40 ++++
 rtl/alu_op_decode.sv | 60 ++++++
 rtl/alu_issue_ctrl.sv | 165 ++++++++++++++++
 tb/tb_alu_issue_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared definitions for the ALU issue controller: 4-bit ALU
//                control codes, aluop encodings, funct3 constants, decode
//                result structure and the issuer state enumeration.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    // ALU control codes as understood by the datapath ALU
    localparam logic [3:0] C_ALU_AND     = 4'b0000;
    localparam logic [3:0] C_ALU_OR      = 4'b0001;
    localparam logic [3:0] C_ALU_ADD     = 4'b0010;
    localparam logic [3:0] C_ALU_SUB     = 4'b0110;
    localparam logic [3:0] C_ALU_NOR     = 4'b1100;
    localparam logic [3:0] C_ALU_ILLEGAL = 4'b1111;

    // aluop field produced by the multi-cycle control unit
    localparam logic [1:0] C_ALUOP_MEM    = 2'b00;
    localparam logic [1:0] C_ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] C_ALUOP_RTYPE  = 2'b10;
    localparam logic [1:0] C_ALUOP_ITYPE  = 2'b11;

    // funct3 values that select a supported operation
    localparam logic [2:0] C_F3_ADDSUB = 3'b000;
    localparam logic [2:0] C_F3_BEQ    = 3'b000;
    localparam logic [2:0] C_F3_BNE    = 3'b001;
    localparam logic [2:0] C_F3_OR     = 3'b110;
    localparam logic [2:0] C_F3_AND    = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_CAPT = 2'd2,
        ST_RESP = 2'd3
    } state_e;

endpackage : alu_pkg
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_decode
//  Description : Combinational decode of aluop/funct3/funct7b5 into the ALU
//                control code plus branch and illegal flags.
//  Ports       : aluop_i, funct3_i, funct7b5_i -> code_o, is_branch_o,
//                illegal_o
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [1:0] aluop_i,
    input  logic [2:0] funct3_i,
    input  logic       funct7b5_i,
    output logic [3:0] code_o,
    output logic       is_branch_o,
    output logic       illegal_o
);

    always_comb begin
        code_o      = C_ALU_ILLEGAL;
        is_branch_o = 1'b0;
        illegal_o   = 1'b0;
        case (aluop_i)
            C_ALUOP_MEM: begin
                code_o = C_ALU_ADD;
            end
            C_ALUOP_BRANCH: begin
                // Only beq/bne are supported; anything else is sent to the
                // ALU as the illegal code so the result reads back as zero.
                is_branch_o = 1'b1;
                if (funct3_i == C_F3_BEQ || funct3_i == C_F3_BNE) begin
                    code_o = C_ALU_SUB;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            C_ALUOP_RTYPE: begin
                case (funct3_i)
                    C_F3_ADDSUB: code_o = funct7b5_i ? C_ALU_SUB : C_ALU_ADD;
                    C_F3_AND:    code_o = C_ALU_AND;
                    C_F3_OR:     code_o = C_ALU_OR;
                    default:     illegal_o = 1'b1;
                endcase
            end
            C_ALUOP_ITYPE: begin
                // addi has no subtract form, so bit 30 is ignored here
                case (funct3_i)
                    C_F3_ADDSUB: code_o = C_ALU_ADD;
                    C_F3_AND:    code_o = C_ALU_AND;
                    C_F3_OR:     code_o = C_ALU_OR;
                    default:     illegal_o = 1'b1;
                endcase
            end
        endcase
    end

endmodule : alu_op_decode
`default_nettype wire

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : alu_issue_ctrl
//  Description : Sequential issuer sitting between the multi-cycle control
//                unit and the ALU. Accepts a request (valid/ready), drives the
//                registered ALU control code and operands, waits ALU_LATENCY
//                edges, captures ALUOut/zero and returns the result with a
//                branch decision (valid/ready).
//  Ports       : clock, reset (sync, active-low)
//                req_*   : request handshake and fields
//                ALUControl/input1/input2 -> ALU, ALUOut/zero <- ALU
//                resp_*  : response handshake and captured results
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int unsigned ALU_LATENCY = 1,
    parameter int unsigned WIDTH       = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_aluop,
    input  logic [2:0]       req_funct3,
    input  logic             req_funct7b5,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    output logic [3:0]       ALUControl,
    output logic [WIDTH-1:0] input1,
    output logic [WIDTH-1:0] input2,
    input  logic [WIDTH-1:0] ALUOut,
    input  logic             zero,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_zero,
    output logic             resp_taken,
    output logic             resp_illegal
);

    localparam logic [2:0] C_LAT = 3'(ALU_LATENCY);

    state_e           state_q, state_d;
    logic [2:0]       cnt_q, cnt_d;
    logic [3:0]       ctrl_q, ctrl_d;
    logic [WIDTH-1:0] in1_q, in1_d;
    logic [WIDTH-1:0] in2_q, in2_d;
    logic             is_branch_q, is_branch_d;
    logic             illegal_q, illegal_d;
    logic             bne_q, bne_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             rzero_q, rzero_d;
    logic             taken_q, taken_d;
    logic             rillegal_q, rillegal_d;

    logic [3:0]       dec_code;
    logic             dec_is_branch;
    logic             dec_illegal;

    alu_op_decode u_decode (
        .aluop_i     (req_aluop),
        .funct3_i    (req_funct3),
        .funct7b5_i  (req_funct7b5),
        .code_o      (dec_code),
        .is_branch_o (dec_is_branch),
        .illegal_o   (dec_illegal)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ctrl_d      = ctrl_q;
        in1_d       = in1_q;
        in2_d       = in2_q;
        is_branch_d = is_branch_q;
        illegal_d   = illegal_q;
        bne_d       = bne_q;
        res_d       = res_q;
        rzero_d     = rzero_q;
        taken_d     = taken_q;
        rillegal_d  = rillegal_q;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d     = ST_EXEC;
                    cnt_d       = C_LAT;
                    ctrl_d      = dec_code;
                    in1_d       = req_a;
                    in2_d       = req_b;
                    is_branch_d = dec_is_branch;
                    illegal_d   = dec_illegal;
                    bne_d       = (req_funct3 == C_F3_BNE);
                end
            end
            ST_EXEC: begin
                // Leave when the counter is about to reach zero so that EXEC
                // lasts exactly ALU_LATENCY cycles.
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = ST_CAPT;
                end
            end
            ST_CAPT: begin
                res_d      = illegal_q ? '0 : ALUOut;
                rzero_d    = zero;
                // beq takes on zero, bne on non-zero
                taken_d    = is_branch_q & ~illegal_q & (zero ^ bne_q);
                rillegal_d = illegal_q;
                state_d    = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            ctrl_q      <= C_ALU_AND;
            in1_q       <= '0;
            in2_q       <= '0;
            is_branch_q <= 1'b0;
            illegal_q   <= 1'b0;
            bne_q       <= 1'b0;
            res_q       <= '0;
            rzero_q     <= 1'b0;
            taken_q     <= 1'b0;
            rillegal_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ctrl_q      <= ctrl_d;
            in1_q       <= in1_d;
            in2_q       <= in2_d;
            is_branch_q <= is_branch_d;
            illegal_q   <= illegal_d;
            bne_q       <= bne_d;
            res_q       <= res_d;
            rzero_q     <= rzero_d;
            taken_q     <= taken_d;
            rillegal_q  <= rillegal_d;
        end
    end

    assign req_ready    = (state_q == ST_IDLE);
    assign resp_valid   = (state_q == ST_RESP);
    assign ALUControl   = ctrl_q;
    assign input1       = in1_q;
    assign input2       = in2_q;
    assign resp_result  = res_q;
    assign resp_zero    = rzero_q;
    assign resp_taken   = taken_q;
    assign resp_illegal = rillegal_q;

endmodule : alu_issue_ctrl
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_issue_ctrl
//  Description : Scoreboard bench for alu_issue_ctrl. Two instances
//                (ALU_LATENCY 1 and 3) each drive a behavioural pipelined
//                ALU. Stimulus pushes expected responses; a monitor checks
//                handshake timing, operand stability and response content.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_issue_ctrl;

    localparam int W  = 32;
    localparam int NI = 2;
    localparam int STALL_MAX = 300;

    typedef struct packed {
        logic [3:0]   code;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] result;
        logic         zero;
        logic         taken;
        logic         illegal;
    } exp_t;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic         reset        [NI];
    logic         req_valid    [NI];
    logic         req_ready    [NI];
    logic [1:0]   req_aluop    [NI];
    logic [2:0]   req_funct3   [NI];
    logic         req_funct7b5 [NI];
    logic [W-1:0] req_a        [NI];
    logic [W-1:0] req_b        [NI];
    logic [3:0]   ALUControl   [NI];
    logic [W-1:0] input1       [NI];
    logic [W-1:0] input2       [NI];
    logic [W-1:0] ALUOut       [NI];
    logic         zero         [NI];
    logic         resp_valid   [NI];
    logic         resp_ready   [NI];
    logic [W-1:0] resp_result  [NI];
    logic         resp_zero    [NI];
    logic         resp_taken   [NI];
    logic         resp_illegal [NI];

    exp_t sb [NI][$];

    int compared   = 0;
    int mismatched = 0;
    bit fin        = 1'b0;
    bit fin_done   = 1'b0;

    function automatic int lat(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    // Behavioural ALU arithmetic, keyed on the control code
    function automatic logic [W-1:0] alu_fn(input logic [3:0] c, input logic [W-1:0] x, input logic [W-1:0] y);
        case (c)
            4'b0000: return x & y;
            4'b0001: return x | y;
            4'b0010: return x + y;
            4'b0110: return x - y;
            4'b1100: return ~(x | y);
            default: return '0;
        endcase
    endfunction

    // Reference model: decide the operation from the instruction fields,
    // then derive every response field arithmetically.
    function automatic exp_t model(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                                   input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int sel;               // 0 add, 1 sub, 2 and, 3 or, -1 illegal
        sel = -1;
        if (op == 2'd0) sel = 0;
        else if (op == 2'd1) sel = (f3 == 3'd0 || f3 == 3'd1) ? 1 : -1;
        else begin
            if (f3 == 3'd0) sel = (op == 2'd2 && f7) ? 1 : 0;
            else if (f3 == 3'd7) sel = 2;
            else if (f3 == 3'd6) sel = 3;
        end
        e.a = a;
        e.b = b;
        e.illegal = (sel < 0);
        case (sel)
            0:       begin e.code = 4'b0010; e.result = a + b; end
            1:       begin e.code = 4'b0110; e.result = a - b; end
            2:       begin e.code = 4'b0000; e.result = a & b; end
            3:       begin e.code = 4'b0001; e.result = a | b; end
            default: begin e.code = 4'b1111; e.result = '0;    end
        endcase
        e.zero  = (e.result == 0);
        e.taken = (op == 2'd1) && !e.illegal && ((f3 == 3'd0) ? e.zero : !e.zero);
        return e;
    endfunction

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        localparam int LAT = (gi == 0) ? 1 : 3;
        logic [W-1:0] pipe [8];

        alu_issue_ctrl #(
            .ALU_LATENCY (LAT),
            .WIDTH       (W)
        ) u_dut (
            .clock        (clock),
            .reset        (reset[gi]),
            .req_valid    (req_valid[gi]),
            .req_ready    (req_ready[gi]),
            .req_aluop    (req_aluop[gi]),
            .req_funct3   (req_funct3[gi]),
            .req_funct7b5 (req_funct7b5[gi]),
            .req_a        (req_a[gi]),
            .req_b        (req_b[gi]),
            .ALUControl   (ALUControl[gi]),
            .input1       (input1[gi]),
            .input2       (input2[gi]),
            .ALUOut       (ALUOut[gi]),
            .zero         (zero[gi]),
            .resp_valid   (resp_valid[gi]),
            .resp_ready   (resp_ready[gi]),
            .resp_result  (resp_result[gi]),
            .resp_zero    (resp_zero[gi]),
            .resp_taken   (resp_taken[gi]),
            .resp_illegal (resp_illegal[gi])
        );

        // Registered ALU with LAT edges from operand drive to result
        always @(posedge clock) begin
            pipe[0] <= alu_fn(ALUControl[gi], input1[gi], input2[gi]);
            for (int s = 1; s < 8; s++) pipe[s] <= pipe[s-1];
        end
        assign ALUOut[gi] = pipe[LAT-1];
        assign zero[gi]   = (pipe[LAT-1] == '0);
    end

    task automatic chk(input string name, input int k, input logic [W-1:0] act, input logic [W-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s dut%0d t=%0t got=%h expected=%h", name, k, $time, act, exp);
        end
    endtask

    // ---------------------------------------------------------------- monitor
    bit busy     [NI] = '{default: 1'b0};
    bit acc_pend [NI] = '{default: 1'b0};
    bit hs_pend  [NI] = '{default: 1'b0};
    bit rst_pend [NI] = '{default: 1'b0};
    int ncyc     [NI] = '{default: 0};

    initial begin
        forever begin
            @(negedge clock);
            for (int k = 0; k < NI; k++) begin
                int L;
                L = lat(k);
                if (rst_pend[k]) begin
                    busy[k] = 1'b0;
                    ncyc[k] = 0;
                    chk("rst_req_ready",  k, W'(req_ready[k]), 1);
                    chk("rst_resp_valid", k, W'(resp_valid[k]), 0);
                    chk("rst_ALUControl", k, W'(ALUControl[k]), 0);
                    chk("rst_input1",     k, input1[k], 0);
                    chk("rst_input2",     k, input2[k], 0);
                    chk("rst_resp_result",k, resp_result[k], 0);
                    chk("rst_resp_flags", k, W'({resp_zero[k], resp_taken[k], resp_illegal[k]}), 0);
                end else begin
                    if (acc_pend[k]) begin
                        busy[k] = 1'b1;
                        ncyc[k] = 0;
                    end else if (hs_pend[k]) begin
                        busy[k] = 1'b0;
                    end
                    if (busy[k]) begin
                        ncyc[k]++;
                        chk("busy_req_ready", k, W'(req_ready[k]), 0);
                        chk("resp_valid_timing", k, W'(resp_valid[k]), W'(ncyc[k] >= L + 2));
                        if (sb[k].size() == 0) begin
                            compared++;
                            mismatched++;
                            $display("FAIL no_expected_entry dut%0d t=%0t got=busy expected=idle", k, $time);
                        end else begin
                            chk("ALUControl", k, W'(ALUControl[k]), W'(sb[k][0].code));
                            chk("input1",     k, input1[k], sb[k][0].a);
                            chk("input2",     k, input2[k], sb[k][0].b);
                            if (resp_valid[k]) begin
                                chk("resp_result",  k, resp_result[k], sb[k][0].result);
                                chk("resp_zero",    k, W'(resp_zero[k]), W'(sb[k][0].zero));
                                chk("resp_taken",   k, W'(resp_taken[k]), W'(sb[k][0].taken));
                                chk("resp_illegal", k, W'(resp_illegal[k]), W'(sb[k][0].illegal));
                            end
                        end
                        if (ncyc[k] > L + 2 + STALL_MAX) begin
                            compared++;
                            mismatched++;
                            $display("FAIL resp_timeout dut%0d t=%0t got=%0d cycles expected<=%0d", k, $time, ncyc[k], L + 2 + STALL_MAX);
                            busy[k] = 1'b0;
                        end
                    end else begin
                        chk("idle_req_ready",  k, W'(req_ready[k]), 1);
                        chk("idle_resp_valid", k, W'(resp_valid[k]), 0);
                    end
                end
                // Record what the coming rising edge will do
                rst_pend[k] = !reset[k];
                acc_pend[k] = reset[k] && req_valid[k] && req_ready[k];
                hs_pend[k]  = reset[k] && resp_valid[k] && resp_ready[k];
                if (hs_pend[k] && sb[k].size() > 0) void'(sb[k].pop_front());
            end
            if (fin && !fin_done) begin
                for (int k = 0; k < NI; k++) chk("scoreboard_empty", k, W'(sb[k].size()), 0);
                fin_done = 1'b1;
            end
        end
    end

    // --------------------------------------------------------------- stimulus
    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic issue(input int k, input logic [1:0] op, input logic [2:0] f3, input logic f7,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        bit acc;
        acc = 1'b0;
        req_aluop[k]    = op;
        req_funct3[k]   = f3;
        req_funct7b5[k] = f7;
        req_a[k]        = a;
        req_b[k]        = b;
        req_valid[k]    = 1'b1;
        for (int c = 0; c < 64 && !acc; c++) begin
            acc = req_ready[k];
            @(posedge clock);
            #1;
        end
        req_valid[k] = 1'b0;
        if (acc) sb[k].push_back(model(op, f3, f7, a, b));
        // Fields must be ignored after the accept edge
        req_aluop[k]    = 2'($urandom);
        req_funct3[k]   = 3'($urandom);
        req_funct7b5[k] = 1'($urandom);
        req_a[k]        = $urandom;
        req_b[k]        = $urandom;
    endtask

    task automatic drain(input int k, input bit rnd);
        bit hs;
        hs = 1'b0;
        for (int c = 0; c < 200 && !hs; c++) begin
            resp_ready[k] = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            hs = resp_valid[k] && resp_ready[k];
            @(posedge clock);
            #1;
        end
        resp_ready[k] = 1'b1;
    endtask

    initial begin
        logic [2:0]   f3s [4];
        logic [1:0]   op;
        logic [2:0]   f3;
        logic [W-1:0] a;
        f3s = '{3'd0, 3'd1, 3'd6, 3'd7};
        for (int k = 0; k < NI; k++) begin
            reset[k]        = 1'b0;
            req_valid[k]    = 1'b0;
            resp_ready[k]   = 1'b1;
            req_aluop[k]    = '0;
            req_funct3[k]   = '0;
            req_funct7b5[k] = 1'b0;
            req_a[k]        = '0;
            req_b[k]        = '0;
        end
        step(3);
        for (int k = 0; k < NI; k++) reset[k] = 1'b1;
        step(2);

        for (int k = 0; k < NI; k++) begin
            issue(k, 2'b10, 3'b000, 1'b0, 32'd7, 32'd5);            drain(k, 0);
            issue(k, 2'b01, 3'b000, 1'b0, 32'h1234, 32'h1234);      drain(k, 0);
            issue(k, 2'b01, 3'b001, 1'b0, 32'h1234, 32'h1234);      drain(k, 0);
            issue(k, 2'b01, 3'b001, 1'b0, 32'd5, 32'd3);            drain(k, 0);
            issue(k, 2'b01, 3'b100, 1'b0, 32'd9, 32'd9);            drain(k, 0);
            issue(k, 2'b10, 3'b000, 1'b1, 32'd3, 32'd20);           drain(k, 0);
            issue(k, 2'b00, 3'b101, 1'b1, 32'hFFFF_FFFF, 32'd1);    drain(k, 0);
            // Response backpressure for several cycles
            resp_ready[k] = 1'b0;
            issue(k, 2'b11, 3'b000, 1'b1, 32'd10, 32'd3);
            step(lat(k) + 6);
            drain(k, 0);
            issue(k, 2'b10, 3'b001, 1'b0, 32'd1, 32'd2);            drain(k, 0);
            issue(k, 2'b11, 3'b111, 1'b0, 32'hFF00, 32'h0FF0);      drain(k, 0);
            // Reset while the operation is executing
            issue(k, 2'b10, 3'b000, 1'b0, 32'd1, 32'd2);
            reset[k] = 1'b0;
            step(1);
            reset[k] = 1'b1;
            sb[k].delete();
            step(3);
            issue(k, 2'b10, 3'b110, 1'b0, 32'hF0, 32'h0F);          drain(k, 0);
            repeat (40) begin
                op = 2'($urandom);
                f3 = ($urandom_range(0, 3) != 0) ? f3s[$urandom_range(0, 3)] : 3'($urandom);
                a  = $urandom;
                issue(k, op, f3, 1'($urandom), a, ($urandom_range(0, 3) == 0) ? a : $urandom);
                drain(k, 1);
            end
        end

        step(3);
        fin = 1'b1;
        for (int c = 0; c < 20 && !fin_done; c++) step(1);
        if (!fin_done) $display("FAIL final_check dut- got=not_reached expected=reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog t=%0t got=running expected=finished", $time);
        $fatal(1, "watchdog expired");
    end

endmodule : tb_alu_issue_ctrl
`default_nettype wire
